// File: rtl/ula_pkg.sv
// Shared constants and FSM encoding for the ALU datapath blocks.
package ula_pkg;

  localparam int LARGURA = 8;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/somador_8bits.sv
// 8-bit ripple-carry adder: S = A + B + C_in, carry out on C_out.
module somador_8bits
  import ula_pkg::*;
(
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  logic               C_in,
  output logic [LARGURA-1:0] S,
  output logic               C_out
);

  logic [LARGURA:0] c;

  assign c[0] = C_in;

  for (genvar i = 0; i < LARGURA; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign C_out = c[LARGURA];

endmodule

// File: rtl/multiplicador_8bits_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around somador_8bits.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip the iteration phase.
module multiplicador_8bits_seq
  import ula_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LARGURA-1:0]     A,
  input  logic [LARGURA-1:0]     B,
  output logic [2*LARGURA-1:0]   P,
  output logic                   busy,
  output logic                   done
);

  // Handshake: start is taken on any edge where the block is not in CALC
  // (IDLE or DONE); done pulses for exactly the one cycle P has just updated.

  estado_t            state, next_state;
  logic [LARGURA-1:0] md, m, acc;
  logic [CNT_W-1:0]   cnt;
  logic [LARGURA-1:0] parcela, soma;
  logic               carry;
  logic               accept, last, bypass;

  assign parcela = m[0] ? md : '0;
  assign accept  = start && (state != CALC);
  assign last    = (state == CALC) && (cnt == CNT_W'(LARGURA - 1));

`ifdef MULT_ZERO_BYPASS_EN
  assign bypass = accept && ((A == '0) || (B == '0));
`else
  assign bypass = 1'b0;
`endif

  somador_8bits u_somador (
    .A     (acc),
    .B     (parcela),
    .C_in  (1'b0),
    .S     (soma),
    .C_out (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = bypass ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) next_state = bypass ? DONE : CALC;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The carry of each step shifts into acc[7], so no product bit is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      md  <= '0;
      m   <= '0;
      acc <= '0;
      cnt <= '0;
      P   <= '0;
    end else if (accept) begin
      md  <= A;
      m   <= B;
      acc <= '0;
      cnt <= '0;
      if (bypass) P <= '0;
    end else if (state == CALC) begin
      acc <= {carry, soma[LARGURA-1:1]};
      m   <= {soma[0], m[LARGURA-1:1]};
      cnt <= cnt + 1'b1;
      if (last) P <= {carry, soma, m[LARGURA-1:1]};
    end
  end

endmodule

// File: tb/tb_multiplicador_8bits_seq.sv
// Self-checking bench for multiplicador_8bits_seq; honours MULT_ZERO_BYPASS_EN.
module tb_multiplicador_8bits_seq;

`ifdef MULT_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  op_a, op_b;
  logic [15:0] P;
  logic        busy, done;

  logic [15:0] exp_q[$];
  logic [15:0] last_p;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_accepted = 0;
  int          n_done = 0;

  multiplicador_8bits_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (op_a),
    .B     (op_b),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_done", done, 1'b0);
      check("idle_p_hold", P, last_p);
    end
  endtask

  // Drives one operation from the current cycle (IDLE or DONE) and walks its
  // timeline; poke_at > 0 raises a stray start during that CALC cycle.
  task automatic mult(input logic [7:0] a, input logic [7:0] b, input int poke_at);
    int lat;
    lat = (ZERO_BYPASS && (a == 8'd0 || b == 8'd0)) ? 1 : 9;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    exp_q.push_back(16'(a) * 16'(b));
    n_accepted++;
    tick();
    start = 1'b0;
    op_a  = ~a;
    op_b  = b ^ 8'h5A;
    for (int i = 1; i < lat; i++) begin
      check("calc_busy", busy, 1'b1);
      check("calc_done", done, 1'b0);
      check("calc_p_hold", P, last_p);
      if (i == poke_at) begin
        start = 1'b1;
        op_a  = 8'd1;
        op_b  = 8'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_p", P, 16'(a) * 16'(b));
    last_p = 16'(a) * 16'(b);
  endtask

  // Scoreboard: every done pulse pops one expected product.
  always @(posedge clk) begin
    #1;
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) check("spurious_done", done, 1'b0);
      else                   check("sb_product", P, exp_q.pop_front());
    end
  end

  initial begin
    logic [7:0] ra, rb;
    rst    = 1'b1;
    start  = 1'b0;
    op_a   = 8'd0;
    op_b   = 8'd0;
    last_p = 16'h0000;
    tick();
    tick();
    check("rst_p", P, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    idle(2);

    mult(8'd13, 8'd11, 0);
    idle(3);
    mult(8'd255, 8'd255, 0);
    idle(1);

    // Stray start in CALC ignored, then back-to-back start in DONE.
    mult(8'd200, 8'd7, 3);
    mult(8'd2, 8'd3, 0);
    idle(2);

    // Reset during the 4th CALC cycle aborts silently.
    op_a  = 8'd99;
    op_b  = 8'd77;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_p", P, 16'h0000);
    last_p = 16'h0000;
    idle(12);

    mult(8'd0, 8'd77, 0);
    idle(2);
    mult(8'd1, 8'd255, 0);
    mult(8'd128, 8'd2, 0);
    idle(1);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) ra = 8'd0;
      if ($urandom_range(0, 15) == 0) rb = 8'd0;
      mult(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    check("done_count", n_done, n_accepted);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
